svnet_pipe_ctrl: RTL and testbench

SVNET_PIPE_CTRL -- requirements
Module: svnet_pipe_ctrl

---
 rtl/svnet_pipe_ctrl_if.sv | 26 ++
 rtl/svnet_pipe_ctrl.sv | 72 +++++++
 tb/tb_svnet_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/svnet_pipe_ctrl_if.sv
// Handshake bundle between upstream producer, pipeline controller and downstream consumer.
interface svnet_pipe_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic flush;

  // Producer/consumer side: drives requests, observes controller handshakes.
  modport master (
    output in_valid,
    output out_ready,
    output flush,
    input  in_ready,
    input  out_valid
  );

  // Controller side.
  modport slave (
    input  in_valid,
    input  out_ready,
    input  flush,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/svnet_pipe_ctrl.sv
// Valid/enable sequencer for a DEPTH-stage datapath pipeline with bubble collapse,
// flush and a registered occupancy count.
module svnet_pipe_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  svnet_pipe_ctrl_if.slave           pipe,
  output logic [DEPTH-1:0]           stage_en,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       busy
);
  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] en_raw;
  logic [OW-1:0]    occ;
  logic             accept;
  logic             emit;

  // A stage may load when it is empty or its successor is loading; the chain is
  // carried in a local variable so the enable vector has no self-dependency.
  always_comb begin : enable_chain
    logic c;
    en_raw         = '0;
    c              = !v[DEPTH-1] | pipe.out_ready;
    en_raw[DEPTH-1] = c;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      c                    = !v[DEPTH-1-k] | c;
      en_raw[DEPTH-1-k]    = c;
    end
  end

  assign stage_en       = pipe.flush ? '0 : en_raw;
  assign pipe.in_ready  = en_raw[0] & !pipe.flush;
  assign pipe.out_valid = v[DEPTH-1] & !pipe.flush;

  assign accept = pipe.in_valid & pipe.in_ready;
  assign emit   = pipe.out_valid & pipe.out_ready;

  always_comb begin
    v_next = v;
    if (stage_en[0]) v_next[0] = pipe.in_valid;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (stage_en[k]) v_next[k] = v[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v   <= '0;
      occ <= '0;
    end else if (pipe.flush) begin
      v   <= '0;
      occ <= '0;
    end else begin
      v <= v_next;
      case ({accept, emit})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign stage_valid = v;
  assign occupancy   = occ;
  assign busy        = |v;

endmodule

// File: tb/tb_svnet_pipe_ctrl.sv
// Directed + randomized bench for svnet_pipe_ctrl (DEPTH=4) against a token-slot model.
module tb_svnet_pipe_ctrl;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [DEPTH-1:0] stage_en;
  logic [DEPTH-1:0] stage_valid;
  logic [2:0]       occupancy;
  logic             busy;

  svnet_pipe_ctrl_if bus ();

  svnet_pipe_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe        (bus.slave),
    .stage_en    (stage_en),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: each slot holds a token id, -1 when empty.
  int slot [DEPTH];
  int next_tok = 0;
  int tok_q [$];
  int mdl_acc = 0, mdl_emit = 0;
  int dut_acc = 0, dut_emit = 0;
  int cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int occ_mask();
    int m = 0;
    for (int k = 0; k < DEPTH; k++) if (slot[k] >= 0) m |= (1 << k);
    return m;
  endfunction

  function automatic int occ_count();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) if (slot[k] >= 0) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) slot[k] = -1;
    tok_q.delete();
  endtask

  // One clock: drive, check combinational handshake, clock, check registered state.
  task automatic step(input logic iv, input logic ordy, input logic fl);
    bit go [DEPTH];
    int exp_en;
    bit exp_ov, acc, emt;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (fl) go[k] = 1'b0;
      else if (slot[k] < 0) go[k] = 1'b1;
      else if (k == DEPTH - 1) go[k] = ordy;
      else go[k] = go[k+1];
    end
    exp_en = 0;
    for (int k = 0; k < DEPTH; k++) if (go[k]) exp_en |= (1 << k);
    exp_ov = !fl && (slot[DEPTH-1] >= 0);
    chk("stage_en", int'(stage_en), exp_en);
    chk("in_ready", int'(bus.in_ready), int'(go[0]));
    chk("out_valid", int'(bus.out_valid), int'(exp_ov));
    chk("busy", int'(busy), int'(occ_mask() != 0));
    acc = iv && go[0];
    emt = exp_ov && ordy;
    if (bus.in_valid && bus.in_ready) dut_acc++;
    if (bus.out_valid && bus.out_ready) dut_emit++;
    @(posedge clk);
    #1;
    cyc++;
    if (fl) begin
      model_clear();
    end else begin
      if (emt) begin
        void'(tok_q.pop_front());
        mdl_emit++;
      end
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (go[k]) begin
          if (k > 0) slot[k] = slot[k-1];
          else if (acc) slot[k] = next_tok;
          else slot[k] = -1;
        end
      end
      if (acc) begin
        tok_q.push_back(next_tok);
        next_tok++;
        mdl_acc++;
      end
    end
    chk("stage_valid", int'(stage_valid), occ_mask());
    chk("occupancy", int'(occupancy), occ_count());
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_stage_valid"}, int'(stage_valid), 0);
    chk({tag, "_occupancy"}, int'(occupancy), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_stage_en"}, int'(stage_en), 15);
  endtask

  int acc0, emit0;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    model_clear();
    #1;
    check_reset_state("rst_initial");
    @(negedge clk);
    @(negedge clk);
    check_reset_state("rst_held");
    rst_n = 1'b1;

    // Single word through an empty pipe: visible at the output DEPTH cycles later.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) chk("latency_out_valid", int'(bus.out_valid), 1);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("latency_drained", int'(occupancy), 0);

    // Fill with the consumer stalled.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    chk("full_occ", int'(occupancy), DEPTH);
    chk("full_stage_en", int'(stage_en), 0);
    chk("full_in_ready", int'(bus.in_ready), 0);

    // Full-rate streaming from full.
    acc0 = dut_acc; emit0 = dut_emit;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    chk("stream_accepts", dut_acc - acc0, 10);
    chk("stream_emits", dut_emit - emit0, 10);
    chk("stream_occ", int'(occupancy), DEPTH);

    // Build 1010 with the consumer stalled, then let the bubble collapse.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("bubble_start", int'(stage_valid), 4'b1010);
    #1;
    chk("bubble_en_low", int'(stage_en[1:0]), 3);
    step(1'b0, 1'b0, 1'b0);
    chk("bubble_collapsed", int'(stage_valid), 4'b1100);
    step(1'b0, 1'b0, 1'b0);
    chk("bubble_held", int'(stage_valid), 4'b1100);

    // Flush a full pipe while the consumer is ready.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("pre_flush_full", int'(stage_valid), 4'b1111);
    acc0 = dut_emit;
    step(1'b1, 1'b1, 1'b1);
    chk("flush_no_emit", dut_emit - acc0, 0);
    chk("flush_cleared", int'(stage_valid), 0);

    // Asynchronous reset mid-clock with three words in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("pre_reset_occ", int'(occupancy), 3);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("rst_async");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("post_reset_accept", int'(stage_valid), 4'b0001);

    // Random soak.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b0, 1'b1, 1'b0);
    chk("soak_accepts", dut_acc, mdl_acc);
    chk("soak_emits", dut_emit, mdl_emit);
    chk("soak_drained", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
